// File: rtl/meter_slew_ctrl.sv
// Setpoint sequencer for one moving-coil meter channel: power-up self-test sweep,
// then bounded-step slewing toward a clamped target, updated only on PWM period strobes.
module meter_slew_ctrl #(
    parameter int MOD_WIDTH      = 15,
    parameter int STEP           = 8,
    parameter int FULL_SCALE_CNT = 30000,
    parameter int HOLD_PERIODS   = 64,
    parameter int SELFTEST_EN    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_pwm_strobe,
    input  logic [MOD_WIDTH-1:0] i_target_duty,
    input  logic                 i_target_valid,
    output logic [MOD_WIDTH-1:0] o_mod_setpoint,
    output logic                 o_selftest_busy,
    output logic                 o_settled
);

    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam logic [MOD_WIDTH-1:0] FULL_C    = MOD_WIDTH'(FULL_SCALE_CNT);
    localparam logic [MOD_WIDTH-1:0] STEP_C    = MOD_WIDTH'(STEP);
    localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SWEEP_UP,
        HOLD_TOP,
        SWEEP_DOWN,
        TRACK,
        PARK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [MOD_WIDTH-1:0]   r_setpoint;
    logic [MOD_WIDTH-1:0]   r_target;
    logic [HW-1:0]          r_hold_cnt;
    logic                   r_selftest_done;
    logic                   r_selftest_started;
    logic                   r_busy;
    logic                   r_settled;

    logic [MOD_WIDTH-1:0]   w_goal;
    logic [MOD_WIDTH-1:0]   w_diff;
    logic [MOD_WIDTH-1:0]   w_stepped;
    logic [MOD_WIDTH-1:0]   w_sp_next;
    logic [MOD_WIDTH-1:0]   w_target_next;
    logic [HW-1:0]          w_hold_next;
    logic                   w_done_next;
    logic                   w_started_next;
    logic                   w_ramp;

    assign w_target_next = i_target_valid ?
                           ((i_target_duty > FULL_C) ? FULL_C : i_target_duty) : r_target;

    // The goal uses the already-latched target, so a target arriving on a strobe
    // cycle only takes effect at the following strobe.
    always_comb begin
        w_goal    = r_target;
        w_ramp    = 1'b1;
        w_diff    = '0;
        w_stepped = r_setpoint;
        case (r_state)
            SWEEP_UP:          w_goal = FULL_C;
            SWEEP_DOWN, PARK:  w_goal = '0;
            TRACK:             w_goal = r_target;
            default:           w_ramp = 1'b0;
        endcase
        if (w_goal >= r_setpoint) begin
            w_diff    = w_goal - r_setpoint;
            w_stepped = (w_diff <= STEP_C) ? w_goal : r_setpoint + STEP_C;
        end else begin
            w_diff    = r_setpoint - w_goal;
            w_stepped = (w_diff <= STEP_C) ? w_goal : r_setpoint - STEP_C;
        end
        w_sp_next = (i_pwm_strobe && w_ramp) ? w_stepped : r_setpoint;
    end

    // An aborted self-test counts as started, so it is never repeated before reset.
    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold_cnt;
        w_done_next    = r_selftest_done;
        w_started_next = r_selftest_started;
        case (r_state)
            IDLE: begin
                if (i_en) begin
                    if ((SELFTEST_EN != 0) && !r_selftest_done && !r_selftest_started) begin
                        w_state_next   = SWEEP_UP;
                        w_started_next = 1'b1;
                    end else begin
                        w_state_next = TRACK;
                    end
                end
            end
            PARK: begin
                if (i_en)
                    w_state_next = TRACK;
                else if (i_pwm_strobe && (w_sp_next == '0))
                    w_state_next = IDLE;
            end
            default: begin
                if (!i_en) begin
                    w_state_next = PARK;
                end else if (i_pwm_strobe) begin
                    case (r_state)
                        SWEEP_UP: begin
                            if (w_sp_next == FULL_C) begin
                                w_state_next = HOLD_TOP;
                                w_hold_next  = '0;
                            end
                        end
                        HOLD_TOP: begin
                            if (r_hold_cnt == HOLD_LAST)
                                w_state_next = SWEEP_DOWN;
                            else
                                w_hold_next = r_hold_cnt + 1'b1;
                        end
                        SWEEP_DOWN: begin
                            if (w_sp_next == '0) begin
                                w_done_next  = 1'b1;
                                w_state_next = TRACK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= IDLE;
            r_setpoint         <= '0;
            r_target           <= '0;
            r_hold_cnt         <= '0;
            r_selftest_done    <= 1'b0;
            r_selftest_started <= 1'b0;
            r_busy             <= 1'b0;
            r_settled          <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_setpoint         <= w_sp_next;
            r_target           <= w_target_next;
            r_hold_cnt         <= w_hold_next;
            r_selftest_done    <= w_done_next;
            r_selftest_started <= w_started_next;
            r_busy             <= (w_state_next == SWEEP_UP) || (w_state_next == HOLD_TOP) ||
                                  (w_state_next == SWEEP_DOWN);
            r_settled          <= (w_state_next == TRACK) && (w_sp_next == w_target_next);
        end
    end

    assign o_mod_setpoint  = r_setpoint;
    assign o_selftest_busy = r_busy;
    assign o_settled       = r_settled;

endmodule

// File: doc/meter_slew_ctrl.md
Name: meter_slew_ctrl

Overview:
- Sequences the setpoint fed to one moving-coil meter PWM modulator (hour/minute/second channel) in the ammeter clock.
- Takes a raw duty target that has already been through the time LUT, and clamps it to full scale.
- Runs a one-time power-up self-test sweep: 0 → full scale → hold → 0.
- Afterwards it slews the needle toward each new target in bounded steps. Updates occur only at PWM period boundaries, which gives glitch-free duty changes and smooth needle motion, including the 12→0 wrap.

Parameters:
- MOD_WIDTH, 15: setpoint width; matches the modulator.
- STEP, 8: maximum setpoint change per PWM period, in counts.
- FULL_SCALE_CNT, 30000: full-scale deflection count. Targets above this are clamped to it.
- HOLD_PERIODS, 64: number of PWM periods to hold at full scale during self-test.
- SELFTEST_EN, 1: 1 runs the self-test after reset; 0 skips straight to tracking.

Ports:
- clk, in, 1: system clock.
- Rst_n, in, 1: asynchronous active-low reset.
- En, in, 1: channel enable. High means run; low means park the needle at 0.
- pwm_strobe, in, 1: one-cycle pulse at each PWM period start (modulator start_strobe).
- target_duty, in, MOD_WIDTH: requested setpoint.
- target_valid, in, 1: one-cycle qualifier for target_duty.
- mod_setpoint, out, MOD_WIDTH: setpoint to the modulator.
- selftest_busy, out, 1: high while in SWEEP_UP, HOLD_TOP or SWEEP_DOWN.
- settled, out, 1: high in TRACK when mod_setpoint equals the latched target.

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - State=IDLE; mod_setpoint=0; latched target=0; hold counter=0; selftest_done=0; selftest_busy=0; settled=0.
- Target latch:
  - Any cycle, in any state, with target_valid=1 latches min(target_duty, FULL_SCALE_CNT).
  - If target_valid and pwm_strobe coincide, the step in that cycle uses the OLD target. The new target takes effect at the next strobe.
- Step rule, applied only on a pwm_strobe cycle in a ramp state, toward goal G:
  - If |G − cur| ≤ STEP, then cur = G.
  - Otherwise cur moves toward G by STEP.
  - Unsigned arithmetic; no underflow below 0 or overflow above FULL_SCALE_CNT.
  - mod_setpoint is registered and changes the cycle after the strobe. It never changes on a non-strobe cycle.
- States:
  - IDLE
    - mod_setpoint held.
    - On En=1: go to SWEEP_UP if SELFTEST_EN=1 and selftest_done=0, else go to TRACK.
  - SWEEP_UP
    - G = FULL_SCALE_CNT.
    - On reaching G: hold counter cleared, go to HOLD_TOP.
  - HOLD_TOP
    - Counter increments per strobe.
    - After HOLD_PERIODS strobes, go to SWEEP_DOWN.
  - SWEEP_DOWN
    - G = 0.
    - On reaching 0: set selftest_done=1, go to TRACK.
  - TRACK
    - G = latched target.
    - settled = (mod_setpoint == target), registered.
  - PARK
    - G = 0.
    - If En=1 while in PARK: go to TRACK. Self-test is not repeated.
    - On reaching 0 with En=0: go to IDLE.
- En=0 in SWEEP_UP, HOLD_TOP, SWEEP_DOWN or TRACK goes to PARK on the next clock. selftest_done is left unchanged.
  - An aborted self-test is not rerun; it reruns only after reset.
- Wrap (e.g. target drops from 30000 to 0 at 12→0): ordinary downward slew at STEP per period, with no special case.
- Target equal to current in TRACK: no change; settled=1.
- Missing pwm_strobe (modulator held in reset): the setpoint freezes; state transitions that depend on reaching G wait.

Test Plan:
Bench parameters: STEP=8, FULL_SCALE_CNT=64, HOLD_PERIODS=4, strobe every 10 cycles.
1. Release reset, En=1:
   - mod_setpoint steps 8,16,…,64 over 8 strobes, holds 64 for 4 strobes, then steps down to 0 over 8 strobes.
   - selftest_busy=1 throughout, then 0; state is TRACK.
2. In TRACK, target_valid with target_duty=20:
   - mod_setpoint goes 8, 16, 20 on three consecutive strobes; settled=1 after the third.
3. target_duty=100 (above full scale):
   - Latched as 64; mod_setpoint ends at 64.
   - Then target 0: steps down by 8 per strobe to 0 (wrap case).
4. target_valid asserted in the same cycle as a strobe, with the old target equal to current:
   - No change at that strobe; the first step occurs at the next strobe.
5. En=0 at mod_setpoint=40 during SWEEP_UP:
   - PARK ramps 32,…,0, then IDLE.
   - En=1 again goes straight to TRACK; no self-test; selftest_busy stays 0.
6. Assert Rst_n=0 mid-ramp, between strobes:
   - mod_setpoint=0 immediately, without waiting for clk.
   - After release with En=1, the self-test reruns.
